// File: rtl/w_icons_discharge_seq_if.sv
// w_icons_discharge_seq_if: control and status bundle between the management
// side (master) and the electrode discharge sequencer (slave).
interface w_icons_discharge_seq_if #(
  parameter int N_GRP     = 8,
  parameter int DIS_CNT_W = 8
);
  logic                 clk_discharge_main_i;
  logic                 stim_xen_sync_i;
  logic [N_GRP-1:0]     stim_mask_en_i;
  logic                 dis_en_i;
  logic [DIS_CNT_W-1:0] dis_len_i;
  logic                 err_clr_i;
  logic [N_GRP-1:0]     discharge_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 err_overlap_o;

  modport master (
    output clk_discharge_main_i, stim_xen_sync_i, stim_mask_en_i,
           dis_en_i, dis_len_i, err_clr_i,
    input  discharge_o, busy_o, done_o, err_overlap_o
  );

  modport slave (
    input  clk_discharge_main_i, stim_xen_sync_i, stim_mask_en_i,
           dis_en_i, dis_len_i, err_clr_i,
    output discharge_o, busy_o, done_o, err_overlap_o
  );
endinterface

// File: rtl/w_icons_discharge_seq.sv
// w_icons_discharge_seq: after a stimulation burst, shorts every stimulated
// electrode group to the discharge reference for dis_len_i discharge-clock
// ticks, one group at a time with a one-tick gap between groups.
// Optional build macro W_ICONS_DISCHARGE_PARALLEL_EN discharges all pending
// groups together for a single dis_len_i window instead.
module w_icons_discharge_seq #(
  parameter int N_GRP     = 8,
  parameter int DIS_CNT_W = 8
) (
  input logic                     CLK_REC_I,
  input logic                     reset_n_i,
  w_icons_discharge_seq_if.slave  dis_if
);

  localparam int GRP_W = (N_GRP > 1) ? $clog2(N_GRP) : 1;

  typedef enum logic [1:0] {IDLE, STIM, DISCH, GAP} state_t;

  state_t               state_q, state_d;
  logic [N_GRP-1:0]     pend_q, pend_d;
  logic [GRP_W-1:0]     grp_q, grp_d;
  logic [DIS_CNT_W-1:0] cnt_q, cnt_d;
  logic                 clk_dis_q;
  logic [N_GRP-1:0]     discharge_q, discharge_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 tick;
  logic                 errSet;
  logic [DIS_CNT_W-1:0] lenEff;
  logic [DIS_CNT_W:0]   cntInc;
  logic                 lenReached;
  logic [N_GRP-1:0]     pendAcc;
  logic [N_GRP-1:0]     pendLeft;

  function automatic logic [GRP_W-1:0] lowestIdx(input logic [N_GRP-1:0] vec);
    logic [GRP_W-1:0] idx;
    idx = '0;
    for (int i = N_GRP - 1; i >= 0; i--) begin
      if (vec[i]) idx = GRP_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [N_GRP-1:0] oneHot(input logic [GRP_W-1:0] idx);
    logic [N_GRP-1:0] vec;
    vec = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  assign tick       = dis_if.clk_discharge_main_i & ~clk_dis_q;
  assign lenEff     = (dis_if.dis_len_i == '0) ? DIS_CNT_W'(1) : dis_if.dis_len_i;
  assign cntInc     = {1'b0, cnt_q} + (DIS_CNT_W+1)'(1);
  assign lenReached = (cntInc >= {1'b0, lenEff});
  assign pendAcc    = pend_q | dis_if.stim_mask_en_i;

`ifdef W_ICONS_DISCHARGE_PARALLEL_EN
  assign pendLeft = '0;
`else
  assign pendLeft = pend_q & ~oneHot(grp_q);
`endif

  // Next-state, pending-group bookkeeping and registered-output preparation.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    grp_d   = grp_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    errSet  = 1'b0;
    if (!dis_if.dis_en_i) begin
      state_d = IDLE;
      pend_d  = '0;
      grp_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dis_if.stim_xen_sync_i) state_d = STIM;
        end
        STIM: begin
          pend_d = pendAcc;
          if (!dis_if.stim_xen_sync_i) begin
            if (pendAcc == '0) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              grp_d   = lowestIdx(pendAcc);
              cnt_d   = '0;
              state_d = DISCH;
            end
          end
        end
        DISCH: begin
          if (dis_if.stim_xen_sync_i) begin
            errSet  = 1'b1;
            state_d = STIM;
          end else if (tick) begin
            if (lenReached) begin
              pend_d = pendLeft;
              cnt_d  = '0;
              if (pendLeft == '0) begin
                done_d  = 1'b1;
                state_d = IDLE;
              end else begin
                state_d = GAP;
              end
            end else begin
              cnt_d = cntInc[DIS_CNT_W-1:0];
            end
          end
        end
        GAP: begin
          if (dis_if.stim_xen_sync_i) begin
            errSet  = 1'b1;
            state_d = STIM;
          end else if (tick) begin
            grp_d   = lowestIdx(pend_q);
            cnt_d   = '0;
            state_d = DISCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    discharge_d = '0;
    if (state_d == DISCH) begin
`ifdef W_ICONS_DISCHARGE_PARALLEL_EN
      discharge_d = pend_d;
`else
      discharge_d = oneHot(grp_d);
`endif
    end
    busy_d = (state_d == DISCH) || (state_d == GAP);
    err_d  = errSet | (err_q & ~dis_if.err_clr_i);
  end

  // State and output registers; outputs follow the state being entered.
  always_ff @(posedge CLK_REC_I or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      grp_q       <= '0;
      cnt_q       <= '0;
      clk_dis_q   <= 1'b0;
      discharge_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      grp_q       <= grp_d;
      cnt_q       <= cnt_d;
      clk_dis_q   <= dis_if.clk_discharge_main_i;
      discharge_q <= discharge_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign dis_if.discharge_o   = discharge_q;
  assign dis_if.busy_o        = busy_q;
  assign dis_if.done_o        = done_q;
  assign dis_if.err_overlap_o = err_q;

endmodule

// File: doc/w_icons_discharge_seq.md
# w_icons_discharge_seq

Post-stimulation electrode discharge sequencer in the CLK_REC_I domain, directly downstream of the management block. It consumes the divided discharge clock (clk_discharge_main_o), the synchronised stimulation enable, and the per-group stimulation masks. When a stimulation burst ends, it shorts each stimulated electrode group to the discharge reference in turn, for a programmable number of discharge-clock ticks. It flags any stimulation that restarts while discharge is still in progress.

## Interface
- N_GRP, 8, number of stimulation groups (one per stim_mask_en bit)
- DIS_CNT_W, 8, width of the discharge-length counter
- CLK_REC_I  in  1  recording/system clock; the only clock of the block
- reset_n_i  in  1  reset, asynchronous assert, active-low; connect to resetn_top_sync_o
- clk_discharge_main_i  in  1  divided discharge clock from the clock divider; a flop output in the CLK_REC_I domain, so no synchroniser is needed
- stim_xen_sync_i  in  1  synchronised stimulation enable; 1 = stimulation active
- stim_mask_en_i  in  N_GRP  synchronised per-group stimulation mask; bit g = group g stimulated
- dis_en_i  in  1  discharge function enable (register field)
- dis_len_i  in  DIS_CNT_W  discharge ticks per group; 0 is treated as 1
- err_clr_i  in  1  single-cycle clear of err_overlap_o
- discharge_o  out  N_GRP  discharge switch drive, registered
- busy_o  out  1  high while in DISCH or GAP, registered
- done_o  out  1  single-cycle pulse when a discharge sequence completes
- err_overlap_o  out  1  sticky flag: stimulation restarted during discharge

## Operation
- Tick detection:
  - clk_dis_q registers clk_discharge_main_i.
  - tick = clk_discharge_main_i & ~clk_dis_q, i.e. one CLK_REC_I cycle per rising edge of the discharge clock.
- FSM states: IDLE, STIM, DISCH, GAP.
- IDLE → STIM when dis_en_i=1 and stim_xen_sync_i=1.
- STIM:
  - Each cycle, pend |= stim_mask_en_i. This accumulates every group stimulated during the burst.
  - On the cycle where stim_xen_sync_i=0: if pend=0, pulse done_o and go to IDLE. Otherwise, grp = lowest set bit of pend, cnt = 0, go to DISCH.
- DISCH:
  - discharge_o = one-hot(grp).
  - cnt increments on each tick.
  - When a tick makes cnt reach max(dis_len_i,1): clear pend[grp]. If the remaining pend=0, pulse done_o and go to IDLE; otherwise go to GAP.
- GAP:
  - discharge_o = 0.
  - On the next tick: grp = lowest set bit of pend, cnt = 0, go to DISCH. Groups are therefore separated by exactly one tick period with no switch closed.
- Abort on stimulation restart: stim_xen_sync_i=1 while in DISCH or GAP sets err_overlap_o, clears discharge_o, keeps pend, and goes to STIM. The undischarged groups are merged into the next burst.
- Abort on disable: dis_en_i=0 in any state forces IDLE, clears pend, cnt and discharge_o, and does not pulse done_o.
- err_overlap_o clears on err_clr_i. If err_clr_i and a set condition occur in the same cycle, set wins.
- dis_len_i is sampled live. A change in DISCH takes effect on the next comparison; if cnt already ≥ the new length, the group ends on the next tick.
- Reset values: all outputs 0, FSM = IDLE, pend = 0, cnt = 0, clk_dis_q = 0.

## Timing
- All outputs are registered.
- discharge_o asserts 1 cycle after the CLK_REC_I edge on which stim_xen_sync_i is sampled low in STIM.
- discharge_o[grp] deasserts 1 cycle after the dis_len_i-th tick. On-time is therefore dis_len_i ticks minus the partial first period (the first period counts from entry, not from an edge).
- done_o goes high in the same cycle discharge_o returns to 0 for the last group.
- Abort: discharge_o = 0 in the cycle after stim_xen_sync_i=1 is sampled; err_overlap_o asserts in that same cycle.
- tick and stim_xen_sync_i falling in the same cycle in STIM: the entry to DISCH takes priority and the tick is not counted.
- At most one bit of discharge_o is ever set, except under the configuration macro below.

## Configuration
- W_ICONS_DISCHARGE_PARALLEL_EN defined (parallel mode):
  - DISCH drives discharge_o = pend, discharging all pending groups simultaneously.
  - One counter runs for max(dis_len_i,1) ticks, then pend is cleared, done_o pulses, and the FSM goes to IDLE.
  - GAP is unreachable.
- Undefined (default): the sequential one-hot behaviour described above applies.

## Test plan
- Single group, dis_len_i=4, divide-by-4 tick, mask=8'h04, stim burst of 20 cycles: discharge_o=8'h04 for exactly 4 ticks; done_o pulses once; busy_o falls with done_o; err_overlap_o=0.
- Multi group, mask toggles 8'h01 then 8'h82 during the burst, dis_len_i=2: discharge_o goes 8'h01 → 0 (1 tick) → 8'h02 → 0 → 8'h80; never two bits set; done_o pulses after 8'h80.
- Restart during discharge: second burst begins mid-discharge of group 1 of pend=8'h83: discharge_o=0 the next cycle; err_overlap_o=1 and held through err_clr_i=0; after the second burst ends, groups 1 and 7 are discharged.
- Edge cases:
  - dis_len_i=0 gives 1-tick discharge.
  - Empty mask gives a done_o pulse and discharge_o stays 0.
  - dis_en_i dropped mid-DISCH gives IDLE with all outputs 0 and no done_o.
- Async reset asserted mid-DISCH: all outputs 0 immediately without a clock; after release, the block stays in IDLE until the next stim_xen_sync_i rise.
- With W_ICONS_DISCHARGE_PARALLEL_EN, mask 8'h81, dis_len_i=3: discharge_o=8'h81 for 3 ticks, then a done_o pulse.
